// File: rtl/pseudo_spi_rx.sv
// Pseudo-SPI receiver: deserializes an SCLK1/SCLK2/LAT stream LSB-first into a show-ahead FIFO.
// Define PSEUDO_SPI_RX_SYNC_EN to add 2-flop synchronizers on SCLK1, SCLK2, LAT and SPI_SI.
module pseudo_spi_rx #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned RESERVED_DATA_LEN = 8
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic                         SCLK1,
  input  logic                         SCLK2,
  input  logic                         LAT,
  input  logic                         SPI_SI,
  input  logic                         RD,
  output logic [DATA_WIDTH-1:0]        DOUT,
  output logic                         VALID,
  output logic                         FULL,
  output logic [RESERVED_DATA_LEN-1:0] WORD_CNT,
  output logic                         OVF,
  output logic                         FRM_ERR,
  output logic                         RX_DONE
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 2);
  localparam int unsigned LW = RESERVED_DATA_LEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic sclk1_s, sclk2_s, lat_s, si_s;

`ifdef PSEUDO_SPI_RX_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge CLK) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {SCLK1, SCLK2, LAT, SPI_SI};
      sync2_q <= sync1_q;
    end
  end
  assign {sclk1_s, sclk2_s, lat_s, si_s} = sync2_q;
`else
  assign {sclk1_s, sclk2_s, lat_s, si_s} = {SCLK1, SCLK2, LAT, SPI_SI};
`endif

  logic                  sclk1_q, sclk2_q, lat_q;
  logic                  sclk1_edge, sclk2_edge, lat_edge;
  logic [1:0]            state_q, state_d;
  logic [LW-1:0]         len_q, len_d, wcnt_q, wcnt_d;
  logic                  ovf_q, ovf_d, frm_q, frm_d, done_q;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d, sh_cnt;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d, sh_sreg;
  logic                  latch_q, latch_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d, full_q, full_d;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  assign sclk1_edge = sclk1_s & ~sclk1_q;
  assign sclk2_edge = sclk2_s & ~sclk2_q;
  assign lat_edge   = lat_s & ~lat_q;

  // Session FSM, serial shifter and frame-close decision
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    ovf_d     = ovf_q;
    frm_d     = frm_q;
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    latch_d   = latch_q;
    push      = 1'b0;
    pop       = RD & valid_q;
    // A same-cycle SCLK2 edge shifts the old latch value and counts before LAT is judged
    sh_sreg   = sclk2_edge ? {latch_q, sreg_q[DATA_WIDTH-1:1]} : sreg_q;
    sh_cnt    = bit_cnt_q;
    if (sclk2_edge && (bit_cnt_q != CW'(DATA_WIDTH + 1))) sh_cnt = bit_cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (BGN) begin
          len_d     = DATA_LEN;
          wcnt_d    = '0;
          ovf_d     = 1'b0;
          frm_d     = 1'b0;
          bit_cnt_d = '0;
          state_d   = (DATA_LEN == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (!BGN) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end else begin
          if (wcnt_q == len_q) state_d = S_DONE;
          if (sclk1_edge) latch_d = si_s;
          sreg_d    = sh_sreg;
          bit_cnt_d = sh_cnt;
          if (lat_edge) begin
            bit_cnt_d = '0;
            if (sh_cnt == CW'(DATA_WIDTH)) begin
              if (!full_q || pop) begin
                push   = 1'b1;
                wcnt_d = wcnt_q + LW'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end else begin
              frm_d = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (!BGN) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers and registered show-ahead head word
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    dout_d   = dout_q;
    if (wr_ptr_d != rd_ptr_d) begin
      if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) dout_d = sh_sreg;
      else                                               dout_d = mem_q[rd_ptr_d[AW-1:0]];
    end
    valid_d = (wr_ptr_d != rd_ptr_d);
    full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      wcnt_q    <= '0;
      ovf_q     <= 1'b0;
      frm_q     <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      latch_q   <= 1'b0;
      sclk1_q   <= 1'b0;
      sclk2_q   <= 1'b0;
      lat_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      ovf_q     <= ovf_d;
      frm_q     <= frm_d;
      done_q    <= (state_d == S_DONE);
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      latch_q   <= latch_d;
      sclk1_q   <= sclk1_s;
      sclk2_q   <= sclk2_s;
      lat_q     <= lat_s;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      full_q    <= full_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= sh_sreg;
  end

  assign DOUT     = dout_q;
  assign VALID    = valid_q;
  assign FULL     = full_q;
  assign WORD_CNT = wcnt_q;
  assign OVF      = ovf_q;
  assign FRM_ERR  = frm_q;
  assign RX_DONE  = done_q;
endmodule

// File: tb/tb_pseudo_spi_rx.sv
// Self-checking bench for pseudo_spi_rx: directed table, hand-written corner sequences and
// randomized frames checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_pseudo_spi_rx;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW = 8;
`ifdef PSEUDO_SPI_RX_SYNC_EN
  localparam int PH = 2;
  localparam int LAT_DLY = 2;
`else
  localparam int PH = 1;
  localparam int LAT_DLY = 0;
`endif

  logic          CLK = 1'b0;
  logic          rst, BGN, SCLK1, SCLK2, LAT, SPI_SI, RD;
  logic [LW-1:0] DATA_LEN;
  logic [DW-1:0] DOUT;
  logic          VALID, FULL, OVF, FRM_ERR, RX_DONE;
  logic [LW-1:0] WORD_CNT;

  pseudo_spi_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESERVED_DATA_LEN(LW)) dut (
    .CLK(CLK), .rst(rst), .BGN(BGN), .DATA_LEN(DATA_LEN), .SCLK1(SCLK1), .SCLK2(SCLK2),
    .LAT(LAT), .SPI_SI(SPI_SI), .RD(RD), .DOUT(DOUT), .VALID(VALID), .FULL(FULL),
    .WORD_CNT(WORD_CNT), .OVF(OVF), .FRM_ERR(FRM_ERR), .RX_DONE(RX_DONE)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words accepted so far, in arrival order
  logic [7:0] mq[$];
  int         m_wcnt;
  bit         m_ovf, m_frm;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    bit         rd_at;
    bit         e_valid;
    bit         e_full;
    logic [7:0] e_wcnt;
    bit         e_ovf;
    bit         e_frm;
    logic [7:0] e_head;
  } vec_t;
  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(VALID), 32'(mq.size() != 0));
    check({tag, ".full"}, 32'(FULL), 32'(mq.size() == DEPTH));
    check({tag, ".wcnt"}, 32'(WORD_CNT), 32'(m_wcnt));
    check({tag, ".ovf"}, 32'(OVF), 32'(m_ovf));
    check({tag, ".frm"}, 32'(FRM_ERR), 32'(m_frm));
    if (mq.size() != 0) check({tag, ".dout"}, 32'(DOUT), 32'(mq[0]));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".dout"}, 32'(DOUT), 32'(0));
    check({tag, ".valid"}, 32'(VALID), 32'(0));
    check({tag, ".full"}, 32'(FULL), 32'(0));
    check({tag, ".wcnt"}, 32'(WORD_CNT), 32'(0));
    check({tag, ".ovf"}, 32'(OVF), 32'(0));
    check({tag, ".frm"}, 32'(FRM_ERR), 32'(0));
    check({tag, ".done"}, 32'(RX_DONE), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b1; BGN = 1'b0; SCLK1 = 1'b0; SCLK2 = 1'b0; LAT = 1'b0; SPI_SI = 1'b0; RD = 1'b0;
    @(negedge CLK);
    rst = 1'b0;
    mq.delete(); m_wcnt = 0; m_ovf = 1'b0; m_frm = 1'b0;
  endtask

  task automatic start_session(input logic [7:0] len);
    @(negedge CLK); BGN = 1'b0;
    @(negedge CLK); DATA_LEN = len; BGN = 1'b1;
    m_wcnt = 0; m_ovf = 1'b0; m_frm = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge CLK); SPI_SI = b; SCLK1 = 1'b1;
    repeat (PH) @(negedge CLK);
    SCLK1 = 1'b0; SCLK2 = 1'b1;
    repeat (PH) @(negedge CLK);
    SCLK2 = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] data, input int n);
    for (int i = 0; i < n; i++) send_bit((i < 8) ? data[i[2:0]] : 1'b0);
  endtask

  // Returns at the falling edge right after the edge that acts on LAT
  task automatic lat_pulse(input bit rd_at, input bit chk_pre);
    @(negedge CLK); LAT = 1'b1;
    repeat (LAT_DLY) @(negedge CLK);
    if (chk_pre) check("pre_lat.valid", 32'(VALID), 32'(0));
    RD = rd_at;
    @(negedge CLK); RD = 1'b0; LAT = 1'b0;
  endtask

  task automatic model_lat(input logic [7:0] data, input int nbits, input bit rd_at);
    bit popped, was_full;
    was_full = (mq.size() == DEPTH);
    popped = rd_at && (mq.size() != 0);
    if (popped) void'(mq.pop_front());
    if (nbits == DW) begin
      if (!was_full || popped) begin
        mq.push_back(data);
        m_wcnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end else begin
      m_frm = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit rd_at, input bit chk_pre);
    send_bits(data, nbits);
    lat_pulse(rd_at, chk_pre);
    model_lat(data, nbits, rd_at);
  endtask

  task automatic pop();
    @(negedge CLK); RD = 1'b1;
    @(negedge CLK); RD = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    rst = 1'b1; BGN = 1'b0; DATA_LEN = '0; SCLK1 = 1'b0; SCLK2 = 1'b0;
    LAT = 1'b0; SPI_SI = 1'b0; RD = 1'b0;

    vt[0] = '{8'h00, 8, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 8'h00};
    vt[1] = '{8'h05, 8, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 8'h00};
    vt[2] = '{8'h3D, 8, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 8'h00};
    vt[3] = '{8'h9E, 8, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 8'h00};
    vt[4] = '{8'hC3, 8, 1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 8'h00};
    vt[5] = '{8'h11, 7, 1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 8'h00};
    vt[6] = '{8'h77, 8, 1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 8'h05};
    vt[7] = '{8'hAA, 9, 1'b0, 1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 8'h05};

    do_reset();
    check_reset("reset");

    // Basic two-word session and completion timing
    start_session(8'd2);
    send_frame(8'hAB, 8, 1'b0, 1'b1);
    check_all("basic1");
    check("basic1.done", 32'(RX_DONE), 32'(0));
    send_frame(8'h3C, 8, 1'b0, 1'b0);
    check_all("basic2");
    check("basic2.done", 32'(RX_DONE), 32'(0));
    @(negedge CLK);
    check("basic.done_rise", 32'(RX_DONE), 32'(1));
    pop();
    check_all("basic_pop");
    check("basic_pop.dout", 32'(DOUT), 32'h3C);

    // Reset in the middle of a frame, then a clean frame
    start_session(8'd10);
    send_bits(8'h5A, 4);
    do_reset();
    check_reset("midrst");
    start_session(8'd10);
    send_frame(8'h7A, 8, 1'b0, 1'b0);
    check_all("after_rst");
    pop();
    check_all("after_rst_pop");

    // Short frame flags a framing error, next frame is clean
    start_session(8'd10);
    send_frame(8'h2B, 7, 1'b0, 1'b0);
    check_all("frm7");
    send_frame(8'h58, 8, 1'b0, 1'b0);
    check_all("frm_next");
    pop();

    // Table: fill, overflow, framing errors, push+pop at full
    start_session(8'd20);
    for (int k = 0; k < 8; k++) begin
      send_frame(vt[k].data, vt[k].nbits, vt[k].rd_at, 1'b0);
      check($sformatf("vec%0d.valid", k), 32'(VALID), 32'(vt[k].e_valid));
      check($sformatf("vec%0d.full", k), 32'(FULL), 32'(vt[k].e_full));
      check($sformatf("vec%0d.wcnt", k), 32'(WORD_CNT), 32'(vt[k].e_wcnt));
      check($sformatf("vec%0d.ovf", k), 32'(OVF), 32'(vt[k].e_ovf));
      check($sformatf("vec%0d.frm", k), 32'(FRM_ERR), 32'(vt[k].e_frm));
      check($sformatf("vec%0d.dout", k), 32'(DOUT), 32'(vt[k].e_head));
    end
    for (int k = 0; k < 4; k++) begin
      pop();
      check_all($sformatf("drain%0d", k));
    end

    // Push and pop together at full must not overflow
    start_session(8'd20);
    for (int k = 0; k < 4; k++) send_frame(8'(8'h40 + 8'(k)), 8, 1'b0, 1'b0);
    check_all("sim_fill");
    send_frame(8'hE1, 8, 1'b1, 1'b0);
    check_all("sim_pp");
    check("sim_pp.ovf", 32'(OVF), 32'(0));
    check("sim_pp.full", 32'(FULL), 32'(1));
    for (int k = 0; k < 4; k++) begin
      pop();
      check_all($sformatf("sim_drain%0d", k));
    end

    // Abort a session mid-frame: FIFO kept, serial activity ignored while idle
    start_session(8'd20);
    send_frame(8'h12, 8, 1'b0, 1'b0);
    send_frame(8'h34, 8, 1'b0, 1'b0);
    send_bits(8'h0F, 3);
    @(negedge CLK); BGN = 1'b0;
    @(negedge CLK);
    check_all("abort");
    send_bits(8'hFF, 8);
    lat_pulse(1'b0, 1'b0);
    check_all("idle_ignore");
    start_session(8'd20);
    send_frame(8'h6E, 8, 1'b0, 1'b0);
    check_all("resume");
    for (int k = 0; k < 3; k++) pop();
    check_all("resume_drain");

    // Zero-length session completes immediately
    start_session(8'd0);
    @(negedge CLK);
    check("len0.done", 32'(RX_DONE), 32'(1));
    check("len0.wcnt", 32'(WORD_CNT), 32'(0));

    // Randomized frames, pops and glitched frame lengths
    start_session(8'd250);
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        pop();
        check_all($sformatf("rnd%0d.pop", it));
      end else begin
        int nb;
        nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 9)) : 8;
        d = 8'($urandom);
        send_frame(d, nb, $urandom_range(0, 3) == 0, 1'b0);
        check_all($sformatf("rnd%0d.frm", it));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pseudo_spi_rx.md
# pseudo_spi_rx

Receive-side companion to the pseudo-SPI transmit interface, which streams 512x8 SRAM contents out over SCLK1/SCLK2/LAT/SPI_SO. The block sits directly downstream of that interface, in the same clock domain. It samples the two-phase serial stream and deserializes it LSB-first into DATA_WIDTH-bit words. Words are buffered in a small FIFO for a parallel consumer, and the block signals completion when DATA_LEN words have been received.

## Interface
- DATA_WIDTH, 8: bits per frame; equals the SRAM word width.
- FIFO_DEPTH, 4: number of buffered words; must be a power of 2, minimum 2.
- RESERVED_DATA_LEN, 8: width of DATA_LEN and WORD_CNT.
- CLK  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- BGN  in  1  level enable for a receive session.
- DATA_LEN  in  RESERVED_DATA_LEN  expected word count; sampled on IDLE->RECV.
- SCLK1  in  1  phase-1 clock from the transmitter; its rising edge samples SPI_SI.
- SCLK2  in  1  phase-2 clock from the transmitter; its rising edge shifts.
- LAT  in  1  frame latch; its rising edge closes the frame.
- SPI_SI  in  1  serial data; connects to the transmitter's SPI_SO.
- RD  in  1  pop request from the consumer.
- DOUT  out  DATA_WIDTH  FIFO head word; valid while VALID=1.
- VALID  out  1  FIFO not empty.
- FULL  out  1  FIFO full.
- WORD_CNT  out  RESERVED_DATA_LEN  accepted words this session.
- OVF  out  1  sticky: a frame was dropped because the FIFO was full.
- FRM_ERR  out  1  sticky: LAT arrived with bit count != DATA_WIDTH.
- RX_DONE  out  1  high in the DONE state.

## Operation
- Edge detection: SCLK1, SCLK2 and LAT are registered once (*_q). An edge is detected in a cycle where the input is 1 and *_q is 0.
- SCLK1 edge: bit_latch <= SPI_SI.
- SCLK2 edge: sreg <= {bit_latch, sreg[DATA_WIDTH-1:1]}; bit_cnt increments and saturates at DATA_WIDTH+1.
  - If SCLK1 and SCLK2 edges occur in the same cycle, the shift uses the old bit_latch.
- LAT edge: the frame closes and bit_cnt is cleared.
  - If bit_cnt == DATA_WIDTH and FIFO not full, or FIFO full with RD in the same cycle: push sreg and increment WORD_CNT.
  - If bit_cnt == DATA_WIDTH, FIFO full and RD=0: drop the frame and set OVF.
  - If bit_cnt != DATA_WIDTH: drop the frame, set FRM_ERR, and leave WORD_CNT unchanged.
- Serial edges are ignored outside RECV. An SCLK2 edge in the same cycle as a LAT edge is applied before the LAT check.
- FSM states: IDLE, RECV, DONE.
  - IDLE: if BGN=1, latch DATA_LEN and clear WORD_CNT, OVF, FRM_ERR and bit_cnt. Go to DONE if DATA_LEN==0, otherwise go to RECV.
  - RECV: go to DONE on the cycle after WORD_CNT reaches the latched DATA_LEN. If BGN=0, go to IDLE; the partial frame is discarded and FIFO contents are kept.
  - DONE: RX_DONE=1. Go to IDLE when BGN=0.
- FIFO:
  - Read and write pointers are one bit wider than log2(FIFO_DEPTH).
  - RD with VALID=0 is ignored.
  - Simultaneous push and pop is legal at any occupancy, including full.
  - DOUT is the registered head word (show-ahead).

## Timing
- Reset values: DOUT=0, VALID=0, FULL=0, WORD_CNT=0, OVF=0, FRM_ERR=0, RX_DONE=0. FSM=IDLE, FIFO empty, sreg=0, bit_latch=0, bit_cnt=0, all *_q=0.
- rst mid-frame or mid-session returns the block to the reset state on the next edge.
- Latency with PSEUDO_SPI_RX_SYNC_EN undefined:
  - VALID rises 1 cycle after the CLK edge that first samples LAT=1.
  - DOUT is valid in that same cycle.
- Pop: VALID and DOUT update on the CLK edge where RD=1 is sampled.
- WORD_CNT updates on the push edge. RX_DONE rises 2 cycles after the final LAT is sampled.
- Minimum serial timing: each SCLK1/SCLK2/LAT high and low phase lasts at least 1 CLK period (2 with SYNC_EN).

## Configuration
- PSEUDO_SPI_RX_SYNC_EN:
  - Defined: SCLK1, SCLK2, LAT and SPI_SI each pass through a 2-flop synchronizer before edge detection. All serial-side latencies grow by 2 cycles, so VALID rises 3 cycles after LAT is first high at the pins. Use this when the transmitter is asynchronous to CLK.
  - Undefined: no synchronizers; inputs feed the edge detectors directly, with the latencies given above.

## Test plan
- Basic frame: BGN=1, DATA_LEN=2; send 0xAB then 0x3C LSB-first. Required: DOUT=0xAB while VALID=1, then 0x3C after one RD; WORD_CNT=2; RX_DONE rises 2 cycles after the second LAT.
- Overflow: FIFO_DEPTH=4, RD held 0, send 5 frames 0x00,0x05,0x3D,0x9E,0xC3. Required: FULL=1 after the 4th frame; OVF=1 after the 5th; WORD_CNT=4; pops return 0x00,0x05,0x3D,0x9E.
- Frame error: send 7 SCLK2 edges then LAT. Required: FRM_ERR=1, VALID=0, WORD_CNT unchanged. The next 8-bit frame 0x58 is received correctly.
- Simultaneous push and pop at full: hold RD=1 on the LAT-detect cycle with 4 words stored. Required: OVF stays 0, FULL stays 1, and the new word appears last in order.
- Reset and abort: assert rst after 4 bits of a frame, then resend 0x7A. Required: all outputs return to reset values and 0x7A is received intact. Separately, drop BGN in RECV: FSM goes to IDLE and FIFO contents are retained.
- SYNC_EN build: rerun the basic-frame scenario. Required: identical data, with VALID delayed by 2 more cycles.
